// File: rtl/uart_alu_ctrl_if.sv
// rtl/uart_alu_ctrl_if.sv - UART byte / ALU / status signal bundle for uart_alu_ctrl
interface uart_alu_ctrl_if #(
    parameter int PAYLOAD_SIZE = 8
);
    logic [PAYLOAD_SIZE-1:0] i_rx_data;
    logic                    i_flg_data_received;
    logic                    i_flg_data_sent;
    logic [PAYLOAD_SIZE-1:0] i_alu_result;
    logic [PAYLOAD_SIZE-1:0] o_alu_a;
    logic [PAYLOAD_SIZE-1:0] o_alu_b;
    logic [PAYLOAD_SIZE-1:0] o_alu_op;
    logic [PAYLOAD_SIZE-1:0] o_tx_data;
    logic                    o_send_data;
    logic                    o_busy;
    logic                    o_err_timeout;
    logic                    o_err_overrun;

    modport slave (
        input  i_rx_data, i_flg_data_received, i_flg_data_sent, i_alu_result,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data,
        output o_send_data, o_busy, o_err_timeout, o_err_overrun
    );

    modport master (
        output i_rx_data, i_flg_data_received, i_flg_data_sent, i_alu_result,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data,
        input  o_send_data, o_busy, o_err_timeout, o_err_overrun
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - collects A, B, opcode bytes from a UART, runs the ALU, sends the result
module uart_alu_ctrl #(
    parameter int PAYLOAD_SIZE   = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_alu_ctrl_if.slave    bus
);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] C_GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] C_GAP_MAX  = {GW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_B,
        S_GET_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [GW-1:0]           r_gap;
    logic [PAYLOAD_SIZE-1:0] r_alu_a;
    logic [PAYLOAD_SIZE-1:0] r_alu_b;
    logic [PAYLOAD_SIZE-1:0] r_alu_op;
    logic [PAYLOAD_SIZE-1:0] r_tx_data;
    logic                    r_send;
    logic                    r_timeout;
    logic                    w_rx;
    logic                    w_gap_expired;
    logic                    w_timeout_now;
    logic                    w_in_gap_state;
    logic                    w_overrun;

    assign w_rx           = bus.i_flg_data_received;
    assign w_gap_expired  = (r_gap == C_GAP_LAST);
    assign w_in_gap_state = (r_state == S_GET_B) || (r_state == S_GET_OP);
    assign w_overrun      = w_rx && ((r_state == S_EXEC) || (r_state == S_SEND) ||
                                     (r_state == S_WAIT_DONE));

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        w_next        = r_state;
        w_timeout_now = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx) w_next = S_GET_B;
            end
            S_GET_B: begin
                if (w_rx) begin
                    w_next = S_GET_OP;
                end else if (w_gap_expired) begin
                    w_next        = S_IDLE;
                    w_timeout_now = 1'b1;
                end
            end
            S_GET_OP: begin
                if (w_rx) begin
                    w_next = S_EXEC;
                end else if (w_gap_expired) begin
                    w_next        = S_IDLE;
                    w_timeout_now = 1'b1;
                end
            end
            S_EXEC:      w_next = S_SEND;
            S_SEND:      w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.i_flg_data_sent) w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_gap     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
            r_send    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_send    <= (w_next == S_SEND);
            r_timeout <= w_timeout_now;

            if ((r_state == S_IDLE) && w_rx)   r_alu_a   <= bus.i_rx_data;
            if ((r_state == S_GET_B) && w_rx)  r_alu_b   <= bus.i_rx_data;
            if ((r_state == S_GET_OP) && w_rx) r_alu_op  <= bus.i_rx_data;
            if (r_state == S_EXEC)             r_tx_data <= bus.i_alu_result;

            // Restart on each new gap state, saturate rather than wrap.
            if (((w_next == S_GET_B) || (w_next == S_GET_OP)) && (w_next != r_state)) begin
                r_gap <= '0;
            end else if (w_in_gap_state && (r_gap != C_GAP_MAX)) begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign bus.o_alu_a       = r_alu_a;
    assign bus.o_alu_b       = r_alu_b;
    assign bus.o_alu_op      = r_alu_op;
    assign bus.o_tx_data     = r_tx_data;
    assign bus.o_send_data   = r_send;
    assign bus.o_busy        = (r_state != S_IDLE);
    assign bus.o_err_timeout = r_timeout;
    assign bus.o_err_overrun = w_overrun;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - directed bench for uart_alu_ctrl with a transmit-byte scoreboard
module tb_uart_alu_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_alu_ctrl_if #(.PAYLOAD_SIZE(8)) bus ();

    // External ALU model: addition.
    assign bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;

    uart_alu_ctrl #(
        .PAYLOAD_SIZE  (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    int         errors   = 0;
    int         checks   = 0;
    int         send_cnt = 0;
    int         to_cnt   = 0;
    int         ov_cnt   = 0;
    int         snap_to;
    int         snap_ov;
    int         snap_send;
    logic [7:0] sb[$];
    logic [7:0] m_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_send_data) begin
                send_cnt++;
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    m_exp = sb.pop_front();
                    check("tx_data", bus.o_tx_data, m_exp);
                end
            end
            if (bus.o_err_timeout) to_cnt++;
            if (bus.o_err_overrun) ov_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data           = b;
        bus.i_flg_data_received = 1'b1;
        tick();
        bus.i_flg_data_received = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] op, input logic [7:0] exp);
        sb.push_back(exp);
        send_byte(op);
        check("exec_no_send", bus.o_send_data, 0);
        tick();
        check("send_latency", bus.o_send_data, 1);
        tick();
        check("send_one_cycle", bus.o_send_data, 0);
        check("wait_busy", bus.o_busy, 1);
    endtask

    task automatic send_done();
        bus.i_flg_data_sent = 1'b1;
        tick();
        bus.i_flg_data_sent = 1'b0;
        check("done_idle", bus.o_busy, 0);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        idle(2);
        send_byte(b);
        idle(2);
        send_op(op, a + b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_rx_data           = '0;
        bus.i_flg_data_received = 1'b0;
        bus.i_flg_data_sent     = 1'b0;
        #3;
        check("rst_busy", bus.o_busy, 0);
        check("rst_outs", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data}, 0);
        check("rst_pulses", {bus.o_send_data, bus.o_err_timeout, bus.o_err_overrun}, 0);
        idle(2);
        rst_n = 1'b1;
        tick();
        check("post_rst_quiet", {bus.o_send_data, bus.o_err_timeout, bus.o_err_overrun, bus.o_busy}, 0);

        // Basic frame, 10-cycle spacing, stray sent pulse during GET_B.
        send_byte(8'h05);
        bus.i_flg_data_sent = 1'b1;
        tick();
        bus.i_flg_data_sent = 1'b0;
        check("sent_ignored", bus.o_busy, 1);
        idle(8);
        send_byte(8'h03);
        idle(9);
        send_op(8'h20, 8'h08);
        check("alu_a", bus.o_alu_a, 8'h05);
        check("alu_b", bus.o_alu_b, 8'h03);
        check("alu_op", bus.o_alu_op, 8'h20);
        send_done();

        // Inter-byte timeout.
        snap_to = to_cnt;
        send_byte(8'h11);
        idle(15);
        check("to_not_yet", bus.o_err_timeout, 0);
        check("to_busy_before", bus.o_busy, 1);
        tick();
        check("to_pulse", bus.o_err_timeout, 1);
        check("to_idle", bus.o_busy, 0);
        check("to_keep_a", bus.o_alu_a, 8'h11);
        tick();
        check("to_one_cycle", bus.o_err_timeout, 0);
        check("to_count", to_cnt - snap_to, 1);
        send_byte(8'h22);
        check("after_to_a", bus.o_alu_a, 8'h22);
        idle(1);
        send_byte(8'h01);
        idle(1);
        send_op(8'h07, 8'h23);
        send_done();

        // Byte arrives on the expiry cycle.
        snap_to = to_cnt;
        send_byte(8'h30);
        idle(15);
        send_byte(8'h40);
        check("edge_b", bus.o_alu_b, 8'h40);
        check("edge_busy", bus.o_busy, 1);
        tick();
        check("edge_no_to", bus.o_err_timeout, 0);
        send_op(8'h01, 8'h70);
        send_done();
        check("edge_to_count", to_cnt - snap_to, 0);

        // Overrun during WAIT_DONE.
        snap_ov = ov_cnt;
        frame(8'h10, 8'h20, 8'h33);
        bus.i_rx_data           = 8'h7F;
        bus.i_flg_data_received = 1'b1;
        #1;
        check("ov_pulse", bus.o_err_overrun, 1);
        @(posedge clk);
        #1;
        bus.i_flg_data_received = 1'b0;
        #1;
        check("ov_clear", bus.o_err_overrun, 0);
        check("ov_tx_keep", bus.o_tx_data, 8'h30);
        check("ov_a_keep", bus.o_alu_a, 8'h10);
        check("ov_busy", bus.o_busy, 1);
        send_done();
        check("ov_count", ov_cnt - snap_ov, 1);

        // Asynchronous reset while in GET_OP.
        send_byte(8'h44);
        idle(1);
        send_byte(8'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.o_busy, 0);
        check("arst_outs", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("arst_quiet", {bus.o_send_data, bus.o_err_timeout, bus.o_busy}, 0);
        frame(8'h06, 8'h07, 8'h09);
        check("arst_a", bus.o_alu_a, 8'h06);
        send_done();

        // Back-to-back frames.
        snap_to   = to_cnt;
        snap_ov   = ov_cnt;
        snap_send = send_cnt;
        frame(8'h01, 8'h02, 8'h11);
        send_done();
        frame(8'h0A, 8'h0B, 8'h12);
        check("b2b_a", bus.o_alu_a, 8'h0A);
        send_done();
        check("b2b_sends", send_cnt - snap_send, 2);
        check("b2b_errs", (to_cnt - snap_to) + (ov_cnt - snap_ov), 0);

        idle(2);
        check("sb_drained", sb.size(), 0);
        check("send_total", send_cnt, 7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 Parameter PAYLOAD_SIZE, default 8: width of every UART byte and ALU operand/result.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: maximum allowed gap, in i_clk cycles, between bytes of one command frame.
REQ-003 i_clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  asynchronous, active-low reset.
REQ-005 i_rx_data  in  PAYLOAD_SIZE  received byte from the UART receiver; valid while i_flg_data_received is high.
REQ-006 i_flg_data_received  in  1  one-cycle pulse: a byte is available on i_rx_data.
REQ-007 i_flg_data_sent  in  1  one-cycle pulse: the UART transmitter has finished a byte.
REQ-008 i_alu_result  in  PAYLOAD_SIZE  combinational result of the external ALU for o_alu_a/o_alu_b/o_alu_op.
REQ-009 o_alu_a  out  PAYLOAD_SIZE  registered operand A.
REQ-010 o_alu_b  out  PAYLOAD_SIZE  registered operand B.
REQ-011 o_alu_op  out  PAYLOAD_SIZE  registered opcode byte.
REQ-012 o_tx_data  out  PAYLOAD_SIZE  registered byte to transmit; stable from the o_send_data pulse until i_flg_data_sent.
REQ-013 o_send_data  out  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_err_timeout  out  1  one-cycle pulse: frame aborted by inter-byte timeout.
REQ-016 o_err_overrun  out  1  one-cycle pulse: byte received while not accepting input; byte discarded.

Function
REQ-017 The FSM SHALL have states IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_DONE.
REQ-018 IDLE: on i_flg_data_received, latch i_rx_data into o_alu_a, go to GET_B.
REQ-019 GET_B: on i_flg_data_received, latch into o_alu_b, go to GET_OP.
REQ-020 GET_OP: on i_flg_data_received, latch into o_alu_op, go to EXEC.
REQ-021 EXEC: lasts exactly one cycle; latch i_alu_result into o_tx_data, go to SEND.
REQ-022 SEND: lasts exactly one cycle; o_send_data high for that cycle only, go to WAIT_DONE.
REQ-023 WAIT_DONE: on i_flg_data_sent, go to IDLE; no timeout in this state.
REQ-024 Latency: o_send_data SHALL rise exactly 2 cycles after the cycle in which the opcode byte's i_flg_data_received is sampled.
REQ-025 Gap counter: cleared on entry to GET_B and GET_OP, incremented every cycle in those states, width ceil(log2(TIMEOUT_CYCLES+1)) bits, no wrap.
REQ-026 When the gap counter reaches TIMEOUT_CYCLES-1 without a received byte: pulse o_err_timeout, return to IDLE; o_alu_a/b/op retain their values.
REQ-027 A byte arriving in the same cycle as the timeout SHALL win: it is accepted, no o_err_timeout pulse.
REQ-028 i_flg_data_received in EXEC, SEND or WAIT_DONE SHALL pulse o_err_overrun that cycle and discard the byte; state unaffected.
REQ-029 i_flg_data_sent outside WAIT_DONE SHALL be ignored.
REQ-030 o_tx_data SHALL change only in EXEC.

Reset
REQ-031 While i_rst is low, state = IDLE and all outputs, the gap counter and all registers SHALL be 0, independent of i_clk.
REQ-032 Reset asserted mid-frame or mid-transmission SHALL abandon the frame; after release the next received byte is treated as operand A.
REQ-033 Outputs SHALL not pulse in the first cycle after reset release unless triggered by an input in that cycle.

Verification
REQ-034 Bytes 0x05, 0x03, 0x20 (ALU model returns A+B) spaced 10 cycles -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_send_data 2 cycles after third pulse with o_tx_data=0x08; i_flg_data_sent -> IDLE, o_busy=0.
REQ-035 TIMEOUT_CYCLES=16: send 0x11 only, wait -> o_err_timeout pulses once, 16 cycles after entry to GET_B; state IDLE; next byte 0x22 lands in o_alu_a.
REQ-036 TIMEOUT_CYCLES=16: second byte arrives exactly on the timeout cycle -> accepted into o_alu_b, no o_err_timeout.
REQ-037 Byte 0x7F injected during WAIT_DONE -> o_err_overrun one-cycle pulse, o_tx_data unchanged, frame completes normally.
REQ-038 Assert i_rst low for 3 cycles while in GET_OP -> all outputs 0 immediately (asynchronously); after release, full 3-byte frame processes correctly.
REQ-039 Two back-to-back frames, second starting the cycle after i_flg_data_sent -> both results transmitted, no error pulses.
